muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 30 +++
 rtl/muldiv_iter_core.sv | 42 ++++
 rtl/muldiv_unit.sv | 112 +++++++++++
 tb/tb_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: funct3 operation codes, FSM state encoding and operand-class helpers
// shared by muldiv_unit and its testbench.
package muldiv_unit_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic op_is_div(input logic [2:0] f);
        return f == F3_DIV || f == F3_DIVU || f == F3_REM || f == F3_REMU;
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f);
        return f == F3_REM || f == F3_REMU;
    endfunction

    function automatic logic op_sgn_a(input logic [2:0] f);
        return f == F3_MULH || f == F3_MULHSU || f == F3_DIV || f == F3_REM;
    endfunction

    function automatic logic op_sgn_b(input logic [2:0] f);
        return f == F3_MULH || f == F3_DIV || f == F3_REM;
    endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned radix-2 engine; shift-add multiply ({o_hi,o_lo} = a*b)
// or restoring divide (o_lo = a/b, o_hi = a%b) after XLEN steps.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN-1:0] r_acc, r_lo, r_b, w_diff;
    logic [XLEN:0]   w_sum, w_shl;
    logic            w_ge;

    assign w_sum  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Partial remainder stays below the divisor, so the difference always fits XLEN bits.
    assign w_shl  = {r_acc, r_lo[XLEN-1]};
    assign w_ge   = w_shl >= {1'b0, r_b};
    assign w_diff = w_shl[XLEN-1:0] - r_b;
    assign o_hi   = r_acc;
    assign o_lo   = r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_lo  <= '0;
            r_b   <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
        end else if (i_step) begin
            r_acc <= i_is_div ? (w_ge ? w_diff : w_shl[XLEN-1:0]) : w_sum[XLEN:1];
            r_lo  <= i_is_div ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension multiply/divide with sign handling and IDLE/CALC/FIX/DONE FSM.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state, w_next;
    logic [2:0]        r_f3;
    logic              r_neg_a, r_neg_b;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              w_accept, w_is_div, w_neg_a, w_neg_b, w_div0, w_ovf, w_fast, w_direct;
    logic              w_res_en;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_hi, w_lo, w_special, w_fast_res, w_fix, w_res_d;
    logic [2*XLEN-1:0] w_prod_fix;

    assign w_accept  = start && !flush && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div  = op_is_div(funct3);
    assign w_neg_a   = op_sgn_a(funct3) && rs1[XLEN-1];
    assign w_neg_b   = op_sgn_b(funct3) && rs2[XLEN-1];
    assign w_mag_a   = w_neg_a ? -rs1 : rs1;
    assign w_mag_b   = w_neg_b ? -rs2 : rs2;
    assign w_div0    = w_is_div && rs2 == '0;
    assign w_ovf     = w_is_div && op_sgn_b(funct3) && rs1 == MIN_NEG && rs2 == '1;
    // Divide-by-zero and signed overflow resolve at accept: quotient -1 or rs1, remainder rs1 or 0.
    assign w_special = op_is_rem(funct3) ? (w_div0 ? rs1 : '0) : (w_div0 ? '1 : rs1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_prod;
    assign w_prod     = {{XLEN{w_neg_a}}, rs1} * {{XLEN{w_neg_b}}, rs2};
    assign w_fast     = !w_is_div;
    assign w_fast_res = funct3 == F3_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    assign w_direct = w_div0 || w_ovf || w_fast;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept && !w_direct),
        .i_step   (r_state == S_CALC),
        .i_is_div (op_is_div(r_f3)),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign w_fix = op_is_div(r_f3)
                 ? (op_is_rem(r_f3) ? (r_neg_a ? -w_hi : w_hi) : ((r_neg_a ^ r_neg_b) ? -w_lo : w_lo))
                 : (r_f3 == F3_MUL ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN]);
    assign w_res_en = !flush && ((w_accept && w_direct) || r_state == S_FIX);
    assign w_res_d  = r_state == S_FIX ? w_fix : (w_fast ? w_fast_res : w_special);

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = S_IDLE;
        else if (w_accept)
            w_next = w_direct ? S_DONE : S_CALC;
        else if (r_state == S_CALC && r_cnt == CW'(XLEN - 1))
            w_next = S_FIX;
        else if (r_state == S_FIX)
            w_next = S_DONE;
        else if (r_state == S_DONE)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_f3     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_state == S_CALC ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_f3    <= funct3;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
            end
            if (w_res_en)
                r_result <= w_res_d;
        end
    end

    assign busy   = r_state == S_CALC || r_state == S_FIX;
    assign done   = r_state == S_DONE;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit (XLEN=32),
// honouring MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_EDGES = 1;
    localparam int MUL_BUSY  = 0;
`else
    localparam int MUL_EDGES = 34;
    localparam int MUL_BUSY  = 33;
`endif

    logic        clk, rst, start, flush, busy, done;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, result;
    int          total = 0;
    int          bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one op starting mid-cycle; edges counts posedges from (and including) the accepting one.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_n, output logic [31:0] res);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs1    = 32'hDEAD_BEEF;
        rs2    = 32'h0;
        funct3 = F3_REMU;
        edges  = 1;
        busy_n = 0;
        while (!done && edges < 100) begin
            busy_n += int'(busy);
            @(posedge clk);
            #1;
            edges++;
        end
        res = result;
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    endtask

    task automatic test_div_iter;
        int e, bn;
        logic [31:0] r;
        run_op(F3_DIV, 32'd100, 32'd7, e, bn, r);
        total++; if (e !== 34) begin bad++; $display("FAIL div_edges got=%0d exp=34", e); end
        total++; if (bn !== 33) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=33", bn); end
        total++; if (r !== 32'd14) begin bad++; $display("FAIL div_result got=%h exp=%h", r, 32'd14); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done); end
        run_op(F3_REM, 32'd100, 32'd7, e, bn, r);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL rem_result got=%h exp=%h", r, 32'd2); end
    endtask

    task automatic test_signed_div;
        logic [2:0]  f[8]   = '{F3_REM, F3_DIV, F3_DIV, F3_REM, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] a[8]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FF9C, 32'hFFFF_FF9C,
                                32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] b[8]   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2, 32'd2};
        logic [31:0] exp[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
                                32'hFFFF_FFF2, 32'd2, 32'h7FFF_FFFC, 32'd1};
        int e, bn;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            run_op(f[i], a[i], b[i], e, bn, r);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL sdiv_%0d got=%h exp=%h", i, r, exp[i]); end
            total++; if (e !== 34) begin bad++; $display("FAIL sdiv_edges_%0d got=%0d exp=34", i, e); end
        end
    endtask

    task automatic test_div_special;
        logic [2:0]  f[6]   = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM};
        logic [31:0] a[6]   = '{32'd5, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[6]   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp[6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0};
        int e, bn;
        logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], a[i], b[i], e, bn, r);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL special_%0d got=%h exp=%h", i, r, exp[i]); end
            total++; if (e !== 1) begin bad++; $display("FAIL special_edges_%0d got=%0d exp=1", i, e); end
            total++; if (bn !== 0) begin bad++; $display("FAIL special_busy_%0d got=%0d exp=0", i, bn); end
        end
    endtask

    task automatic test_mul;
        logic [2:0]  f[7]   = '{F3_MULH, F3_MULHU, F3_MUL, F3_MULHSU, F3_MULH, F3_MUL, F3_MULH};
        logic [31:0] a[7]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd1234, 32'd3};
        logic [31:0] b[7]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd5678, 32'hFFFF_FFFE};
        logic [31:0] exp[7] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF,
                                32'd0, 32'd7006652, 32'hFFFF_FFFF};
        int e, bn;
        logic [31:0] r;
        for (int i = 0; i < 7; i++) begin
            run_op(f[i], a[i], b[i], e, bn, r);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL mul_%0d got=%h exp=%h", i, r, exp[i]); end
            total++; if (e !== MUL_EDGES) begin bad++; $display("FAIL mul_edges_%0d got=%0d exp=%0d", i, e, MUL_EDGES); end
            total++; if (bn !== MUL_BUSY) begin bad++; $display("FAIL mul_busy_%0d got=%0d exp=%0d", i, bn, MUL_BUSY); end
        end
    endtask

    task automatic test_flush;
        int e, bn, seen;
        logic [31:0] r;
        run_op(F3_DIVU, 32'd50, 32'd5, e, bn, r);
        total++; if (r !== 32'd10) begin bad++; $display("FAIL flush_pre got=%h exp=%h", r, 32'd10); end
        funct3 = F3_DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", done); end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen += int'(done);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        total++; if (result !== 32'd10) begin bad++; $display("FAIL flush_result got=%h exp=%h", result, 32'd10); end
        funct3 = F3_DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_beats_start got=%b exp=0", busy); end
    endtask

    task automatic test_start_ignored;
        int e;
        funct3 = F3_DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        funct3 = F3_DIVU; rs1 = 32'd50; rs2 = 32'd5;
        e = 1;
        repeat (20) begin
            @(posedge clk);
            #1;
            e++;
        end
        start = 1'b0;
        while (!done && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
        total++; if (e !== 34) begin bad++; $display("FAIL ignore_edges got=%0d exp=34", e); end
        total++; if (result !== 32'd14) begin bad++; $display("FAIL ignore_result got=%h exp=%h", result, 32'd14); end
    endtask

    task automatic test_back_to_back;
        int e, bn;
        logic [31:0] r;
        run_op(F3_DIV, 32'd100, 32'd7, e, bn, r);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL b2b_first got=%h exp=%h", r, 32'd14); end
        run_op(F3_REM, 32'd100, 32'd7, e, bn, r);
        total++; if (e !== 34) begin bad++; $display("FAIL b2b_edges got=%0d exp=34", e); end
        total++; if (r !== 32'd2) begin bad++; $display("FAIL b2b_second got=%h exp=%h", r, 32'd2); end
        run_op(F3_DIVU, 32'd5, 32'd0, e, bn, r);
        total++; if (e !== 1 || r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_div0 edges=%0d got=%h exp=1/ffffffff", e, r); end
    endtask

    task automatic test_rst_mid;
        int e, bn, seen;
        logic [31:0] r;
        run_op(F3_DIVU, 32'd50, 32'd5, e, bn, r);
        funct3 = F3_DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen += int'(done);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        run_op(F3_DIV, 32'd100, 32'd7, e, bn, r);
        total++; if (e !== 34 || r !== 32'd14) begin bad++; $display("FAIL rst_first_accept edges=%0d got=%h exp=34/0000000e", e, r); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        #12;
        test_reset;
        rst = 1'b0;
        test_div_iter;
        test_signed_div;
        test_div_special;
        test_mul;
        test_flush;
        test_start_ignored;
        test_back_to_back;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
